// File: rtl/complement_unit_if.sv
// Sample-in / result-out stream bundle for complement_unit.
// master = sample source + downstream sink, slave = the unit itself.
interface complement_unit_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/complement_unit.sv
// Per-sample pass / ones' complement / negate / abs with overflow flag and saturating event counter.
// 2-stage valid/ready pipeline: result valid one edge after acceptance; holds 2 samples under backpressure.
module complement_unit #(
  parameter int WIDTH     = 8,
  parameter bit SATURATE  = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  complement_unit_if.slave     bus,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] ovf_count
);
  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ONES = 2'b01,
    MODE_NEG  = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]     MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  mode_e            s1_mode_q,  s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_ovf_q,   s2_ovf_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic             s1_adv;
  logic             s2_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] neg_x;
  logic             is_min;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_xfer  = bus.in_valid && s1_adv;
  assign out_xfer = s2_valid_q && bus.out_ready;

  assign neg_x  = ~s1_data_q + ONE;
  assign is_min = (s1_data_q == MIN_VAL);

  // Only MIN has no positive counterpart; it is the sole overflow source.
  always_comb begin
    res     = s1_data_q;
    res_ovf = 1'b0;
    unique case (s1_mode_q)
      MODE_PASS: res = s1_data_q;
      MODE_ONES: res = ~s1_data_q;
      MODE_NEG: begin
        if (is_min) begin
          res     = SATURATE ? MAX_VAL : MIN_VAL;
          res_ovf = 1'b1;
        end else begin
          res = neg_x;
        end
      end
      MODE_ABS: begin
        if (is_min) begin
          res     = SATURATE ? MAX_VAL : MIN_VAL;
          res_ovf = 1'b1;
        end else if (s1_data_q[WIDTH-1]) begin
          res = neg_x;
        end else begin
          res = s1_data_q;
        end
      end
      default: res = s1_data_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    cnt_d      = cnt_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_xfer) begin
      s1_data_d = bus.in_data;
      s1_mode_d = mode_e'(bus.in_mode);
    end

    // S2 contents only change on advance, so a stalled result stays stable.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = res;
        s2_ovf_d  = res_ovf;
      end
    end

    if (cnt_clear) begin
      cnt_d = '0;
    end else if (out_xfer && s2_ovf_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_PASS;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_ovf   = s2_ovf_q;
  assign ovf_count     = cnt_q;
endmodule

// File: tb/tb_complement_unit.sv
// Three units (saturating, wrapping, 2-bit counter) share one stimulus stream and are
// compared every cycle against an arithmetic reference model with an in-flight sample queue.
module tb_complement_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready;
  logic       cnt_clear;
  logic [15:0] cnt_m;
  logic [15:0] cnt_w;
  logic [1:0]  cnt_c;

  complement_unit_if #(.WIDTH(8)) if_m ();
  complement_unit_if #(.WIDTH(8)) if_w ();
  complement_unit_if #(.WIDTH(8)) if_c ();

  assign if_m.in_valid = in_valid;  assign if_w.in_valid = in_valid;  assign if_c.in_valid = in_valid;
  assign if_m.in_data  = in_data;   assign if_w.in_data  = in_data;   assign if_c.in_data  = in_data;
  assign if_m.in_mode  = in_mode;   assign if_w.in_mode  = in_mode;   assign if_c.in_mode  = in_mode;
  assign if_m.out_ready = out_ready; assign if_w.out_ready = out_ready; assign if_c.out_ready = out_ready;

  complement_unit #(.WIDTH(8), .SATURATE(1'b1), .CNT_WIDTH(16)) u_sat (
    .clk(clk), .rst(rst), .bus(if_m.slave), .cnt_clear(cnt_clear), .ovf_count(cnt_m));
  complement_unit #(.WIDTH(8), .SATURATE(1'b0), .CNT_WIDTH(16)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_w.slave), .cnt_clear(cnt_clear), .ovf_count(cnt_w));
  complement_unit #(.WIDTH(8), .SATURATE(1'b1), .CNT_WIDTH(2)) u_c2 (
    .clk(clk), .rst(rst), .bus(if_c.slave), .cnt_clear(cnt_clear), .ovf_count(cnt_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    int         ed;
  } smp_t;

  smp_t q[$];
  int   edge_cnt = 0;
  int   mcnt16 = 0;
  int   mcnt2 = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  bit   a;
  int   acc_cnt;
  int   cyc;

  // Reference: interpret as a signed integer, apply the math, then fit to 8 bits.
  function automatic void ref_op(input logic [7:0] d, input logic [1:0] m, input bit sat,
                                 output logic [7:0] r, output logic ovf);
    int v;
    int x;
    v = d[7] ? int'(d) - 256 : int'(d);
    case (m)
      2'd0:    x = v;
      2'd1:    x = -v - 1;
      2'd2:    x = -v;
      default: x = (v < 0) ? -v : v;
    endcase
    ovf = (x > 127);
    if (ovf) x = sat ? 127 : x - 256;
    r = x[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input logic [1:0] m, input bit ordy,
                       input bit clr, input bit r, output bit acc);
    smp_t       s;
    logic [7:0] er;
    logic       eo;
    bit         exp_ir, exp_ov, ox, ix;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; cnt_clear = clr; rst = r;
    @(negedge clk);
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (q[0].ed < edge_cnt);
    if (chk_en) begin
      chk("in_ready_sat",  if_m.in_ready,  exp_ir);
      chk("in_ready_wrap", if_w.in_ready,  exp_ir);
      chk("in_ready_c2",   if_c.in_ready,  exp_ir);
      chk("out_valid_sat",  if_m.out_valid, exp_ov);
      chk("out_valid_wrap", if_w.out_valid, exp_ov);
      chk("out_valid_c2",   if_c.out_valid, exp_ov);
      if (exp_ov) begin
        ref_op(q[0].d, q[0].m, 1'b1, er, eo);
        chk("data_sat", if_m.out_data, er);
        chk("ovf_sat",  if_m.out_ovf,  eo);
        chk("data_c2",  if_c.out_data, er);
        ref_op(q[0].d, q[0].m, 1'b0, er, eo);
        chk("data_wrap", if_w.out_data, er);
        chk("ovf_wrap",  if_w.out_ovf,  eo);
      end
      chk("count_sat",  cnt_m, mcnt16);
      chk("count_wrap", cnt_w, mcnt16);
      chk("count_c2",   cnt_c, mcnt2);
    end
    ox  = exp_ov && ordy;
    ix  = v && exp_ir;
    acc = ix && !r;
    eo  = 1'b0;
    if (r) begin
      q.delete();
      mcnt16 = 0;
      mcnt2  = 0;
    end else begin
      if (ox) begin
        ref_op(q[0].d, q[0].m, 1'b1, er, eo);
        void'(q.pop_front());
      end
      if (clr) begin
        mcnt16 = 0;
        mcnt2  = 0;
      end else if (ox && eo) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (ix) begin
        s.d = d; s.m = m; s.ed = edge_cnt + 1;
        q.push_back(s);
      end
    end
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit t;
    cycle(1'b0, 8'h00, 2'd0, ordy, 1'b0, 1'b0, t);
  endtask

  // Sample accepted at edge N must be presented right after edge N+1, then drains at N+2.
  task automatic dir_op(input string tag, input logic [7:0] d, input logic [1:0] m,
                        input logic [7:0] e_sat, input logic [7:0] e_wrap, input bit e_ovf);
    bit t;
    cycle(1'b1, d, m, 1'b1, 1'b0, 1'b0, t);
    idle(1'b1);
    chk({tag, "_valid"},     if_m.out_valid, 1'b1);
    chk({tag, "_data_sat"},  if_m.out_data,  e_sat);
    chk({tag, "_data_wrap"}, if_w.out_data,  e_wrap);
    chk({tag, "_ovf"},       if_m.out_ovf,   e_ovf);
    idle(1'b1);
  endtask

  initial begin
    // Power-up reset; outputs are undefined before it so checking waits.
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, a);
    chk_en = 1'b1;
    chk("rst_out_valid", if_m.out_valid, 1'b0);
    chk("rst_out_data",  if_m.out_data,  8'h00);
    chk("rst_out_ovf",   if_m.out_ovf,   1'b0);
    chk("rst_count",     cnt_m,          16'd0);
    chk("rst_in_ready",  if_m.in_ready,  1'b1);

    dir_op("ones_3c", 8'h3C, 2'b01, 8'hC3, 8'hC3, 1'b0);
    dir_op("neg_05",  8'h05, 2'b10, 8'hFB, 8'hFB, 1'b0);
    dir_op("abs_f6",  8'hF6, 2'b11, 8'h0A, 8'h0A, 1'b0);
    dir_op("pass_7f", 8'h7F, 2'b00, 8'h7F, 8'h7F, 1'b0);
    dir_op("neg_80",  8'h80, 2'b10, 8'h7F, 8'h80, 1'b1);
    chk("neg_80_count", cnt_m, 16'd1);
    dir_op("abs_80",  8'h80, 2'b11, 8'h7F, 8'h80, 1'b1);
    dir_op("ones_80", 8'h80, 2'b01, 8'h7F, 8'h7F, 1'b0);
    chk("overflow_count", cnt_m, 16'd2);

    // Backpressure: two samples fill the pipe, the third waits.
    cycle(1'b1, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_full_in_ready", if_m.in_ready, 1'b0);
    cycle(1'b1, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_hold_data", if_m.out_data, 8'h01);
    cycle(1'b1, 8'h03, 2'd0, 1'b1, 1'b0, 1'b0, a);
    chk("bp_second_out", if_m.out_data, 8'h02);
    repeat (4) idle(1'b1);
    chk("bp_count_kept", cnt_m, 16'd2);

    // Counter saturation at 2 bits, then clear colliding with an overflow transfer.
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, a);
    repeat (5) cycle(1'b1, 8'h80, 2'b10, 1'b1, 1'b0, 1'b0, a);
    repeat (3) idle(1'b1);
    chk("c2_saturated", cnt_c, 2'd3);
    chk("c16_five",     cnt_m, 16'd5);
    cycle(1'b1, 8'h80, 2'b10, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, a);
    chk("clear_wins_c2",  cnt_c, 2'd0);
    chk("clear_wins_c16", cnt_m, 16'd0);

    // Reset in the middle of a stream.
    repeat (6) cycle(1'b1, ($urandom % 2) ? 8'h80 : 8'($urandom), 2'($urandom),
                     1'($urandom), 1'b0, 1'b0, a);
    cycle(1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 8'h22, 2'd0, 1'b0, 1'b0, 1'b1, a);
    chk("midrst_out_valid", if_m.out_valid, 1'b0);
    chk("midrst_count",     cnt_m,          16'd0);
    chk("midrst_in_ready",  if_m.in_ready,  1'b1);
    repeat (4) idle(1'b1);

    // Random traffic with random valid/ready and occasional clears.
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 40000) begin
      cycle(1'($urandom), ($urandom % 8 == 0) ? 8'h80 : 8'($urandom), 2'($urandom),
            1'($urandom), ($urandom % 64 == 0), 1'b0, a);
      if (a) acc_cnt++;
      cyc++;
    end
    chk("random_budget", (acc_cnt >= 10000), 1'b1);
    repeat (4) idle(1'b1);
    chk("drain_empty", if_m.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
